// File: rtl/event_counter_ad.sv
// Per-channel event counters with snapshot shadows, sticky overflow flags and a
// request/pulse register port. Define EVENT_COUNTER_SATURATE_EN for per-channel saturation (MODE).

module event_counter_ad_lane #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap
);
    logic [WIDTH-1:0] r_cnt;
    logic             w_full;

    assign w_full = &r_cnt;
    // Overflow is flagged on any increment from all-ones, wrapping or saturating.
    assign o_wrap = i_inc & w_full;
    assign o_cnt  = r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !(w_full && i_sat)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end
endmodule

module event_counter_ad #(
    parameter int NUM_CHANNELS  = 4,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CHANNELS-1:0] i_event,
    input  logic [7:0]              i_rw_address,
    input  logic                    i_read_request,
    input  logic                    i_write_request,
    input  logic [63:0]             i_write_data,
    output logic [63:0]             o_read_data,
    output logic                    o_output_valid
);
    typedef enum logic {ST_IDLE, ST_WAIT_LOW} state_t;

    state_t r_state, w_state_nxt;
    logic   w_fire, w_rd, w_wr;
    logic   w_sel_ctrl, w_sel_en, w_sel_ovf;
    logic   w_snap, w_clr, w_wr_en, w_wr_ovf;
    logic   w_unused_wdata;

    logic [NUM_CHANNELS-1:0]                    r_enable, r_ovf, w_wrap, w_mode;
    logic [NUM_CHANNELS-1:0][COUNTER_WIDTH-1:0] w_cnt, r_shadow;
    logic                                       r_snap_valid;
    logic [63:0]                                w_rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // A request is serviced once; both request lines must drop before the next one.
    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_read_request || i_write_request) begin
                    w_fire      = 1'b1;
                    w_state_nxt = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!i_read_request && !i_write_request) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wr       = w_fire & i_write_request;
    assign w_rd       = w_fire & ~i_write_request;
    assign w_sel_ctrl = (i_rw_address == 8'h00);
    assign w_sel_en   = (i_rw_address == 8'h01);
    assign w_sel_ovf  = (i_rw_address == 8'h02);
    assign w_snap     = w_wr & w_sel_ctrl & i_write_data[0];
    assign w_clr      = w_wr & w_sel_ctrl & i_write_data[1];
    assign w_wr_en    = w_wr & w_sel_en;
    assign w_wr_ovf   = w_wr & w_sel_ovf;
    assign w_unused_wdata = ^i_write_data;

`ifdef EVENT_COUNTER_SATURATE_EN
    logic                    w_wr_mode;
    logic [NUM_CHANNELS-1:0] r_mode;

    assign w_wr_mode = w_wr & (i_rw_address == 8'h03);
    assign w_mode    = r_mode;

    always_ff @(posedge i_clk) begin
        if (i_rst)          r_mode <= '0;
        else if (w_wr_mode) r_mode <= i_write_data[NUM_CHANNELS-1:0];
    end
`else
    assign w_mode = '0;
`endif

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
        event_counter_ad_lane #(.WIDTH(COUNTER_WIDTH)) u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_inc  (i_event[g] & r_enable[g]),
            .i_clr  (w_clr),
            .i_sat  (w_mode[g]),
            .o_cnt  (w_cnt[g]),
            .o_wrap (w_wrap[g])
        );
    end

    // Shadows capture the pre-increment live values; clear wins over snapshot.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_clr) begin
            r_shadow     <= '0;
            r_snap_valid <= 1'b0;
        end else if (w_snap) begin
            r_shadow     <= w_cnt;
            r_snap_valid <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_enable <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_wr_en) r_enable <= i_write_data[NUM_CHANNELS-1:0];
            r_ovf <= (r_ovf & ~(w_wr_ovf ? i_write_data[NUM_CHANNELS-1:0] : '0)) | w_wrap;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (i_rw_address)
            8'h00: begin
                w_rdata[15:8] = 8'(NUM_CHANNELS);
                w_rdata[0]    = r_snap_valid;
            end
            8'h01: w_rdata[NUM_CHANNELS-1:0] = r_enable;
            8'h02: w_rdata[NUM_CHANNELS-1:0] = r_ovf;
            8'h03: w_rdata[NUM_CHANNELS-1:0] = w_mode;
            default: begin
                for (int n = 0; n < NUM_CHANNELS; n++) begin
                    if (i_rw_address == 8'(16 + n)) w_rdata = 64'(r_shadow[n]);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_read_data    <= '0;
            o_output_valid <= 1'b0;
        end else begin
            o_output_valid <= w_fire;
            if (w_rd)      o_read_data <= w_rdata;
            else if (w_wr) o_read_data <= '0;
        end
    end
endmodule

// File: tb/tb_event_counter_ad.sv
// Bench for event_counter_ad: directed literal scenarios plus randomized traffic
// checked every cycle against an arithmetic model of the register block.
module tb_event_counter_ad;
    localparam int NC = 4;
    localparam int CW = 8;
    localparam longint unsigned MAXV = (64'd1 << CW) - 1;
`ifdef EVENT_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] ev = '0;
    logic [7:0]    addr = '0;
    logic          rd = 1'b0, wr = 1'b0;
    logic [63:0]   wd = '0;
    logic [63:0]   rdata;
    logic          vld;

    always #5 clk = ~clk;

    event_counter_ad #(.NUM_CHANNELS(NC), .COUNTER_WIDTH(CW)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_event         (ev),
        .i_rw_address    (addr),
        .i_read_request  (rd),
        .i_write_request (wr),
        .i_write_data    (wd),
        .o_read_data     (rdata),
        .o_output_valid  (vld)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint unsigned m_cnt[NC];
    longint unsigned m_sh[NC];
    bit [NC-1:0]     m_en, m_ovf, m_mode;
    bit              m_sv, m_locked, m_exp_vld, m_exp_rd, m_started;
    logic [63:0]     m_exp_rdata;

    function automatic logic [63:0] m_read(input logic [7:0] a);
        logic [63:0] r;
        int idx;
        r = '0;
        idx = int'(a) - 16;
        if (a == 8'h00)      r = {48'd0, 8'(NC), 7'd0, m_sv};
        else if (a == 8'h01) r = 64'(m_en);
        else if (a == 8'h02) r = 64'(m_ovf);
        else if (a == 8'h03) r = SAT ? 64'(m_mode) : 64'd0;
        else if (idx >= 0 && idx < NC) r = m_sh[idx];
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit fire, isw, snap, clr, wrap, inc;
        longint unsigned nc;
        logic [63:0] rv;
        m_started = 1'b1;
        if (rst) begin
            for (int n = 0; n < NC; n++) begin m_cnt[n] = 0; m_sh[n] = 0; end
            m_en = '0; m_ovf = '0; m_mode = '0; m_sv = 1'b0; m_locked = 1'b0;
            m_exp_vld = 1'b0; m_exp_rd = 1'b0; m_exp_rdata = '0;
        end else begin
            fire = !m_locked && (rd || wr);
            isw  = fire && wr;
            rv   = m_read(addr);
            snap = isw && addr == 8'h00 && wd[0];
            clr  = isw && addr == 8'h00 && wd[1];
            for (int n = 0; n < NC; n++) begin
                inc  = ev[n] && m_en[n];
                wrap = inc && (m_cnt[n] == MAXV);
                if (!inc)      nc = m_cnt[n];
                else if (wrap) nc = (SAT && m_mode[n]) ? MAXV : 0;
                else           nc = m_cnt[n] + 1;
                if (clr)       m_sh[n] = 0;
                else if (snap) m_sh[n] = m_cnt[n];
                m_cnt[n] = clr ? 0 : nc;
                m_ovf[n] = (m_ovf[n] && !(isw && addr == 8'h02 && wd[n])) || wrap;
            end
            if (clr)       m_sv = 1'b0;
            else if (snap) m_sv = 1'b1;
            if (isw && addr == 8'h01) m_en = wd[NC-1:0];
            if (isw && addr == 8'h03) m_mode = wd[NC-1:0];
            if (fire)           m_locked = 1'b1;
            else if (!rd && !wr) m_locked = 1'b0;
            m_exp_vld = fire;
            m_exp_rd  = fire && !wr;
            if (m_exp_rd) m_exp_rdata = rv;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("valid_vs_model", 64'(vld), 64'(m_exp_vld));
            if (m_exp_vld && m_exp_rd) check("rdata_vs_model", rdata, m_exp_rdata);
        end
    end

    // ---------------- directed helpers ----------------
    // kind: 0 read, 1 write, 2 read+write together
    task automatic xfer(input int kind, input logic [7:0] a, input logic [63:0] d,
                        input logic [NC-1:0] e, output logic [63:0] q);
        int k;
        @(posedge clk); #1;
        addr = a; wd = d; ev = e;
        rd = (kind != 1);
        wr = (kind != 0);
        @(posedge clk); #1;
        ev = '0;
        k = 0;
        while (!vld && k < 8) begin @(posedge clk); #1; k++; end
        check("pulse_latency", 64'(k), 64'd0);
        q = rdata;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [63:0] d);
        logic [63:0] q;
        xfer(1, a, d, '0, q);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [63:0] exp);
        logic [63:0] q;
        xfer(0, a, 64'd0, '0, q);
        check(name, q, exp);
    endtask

    task automatic run_ev(input logic [NC-1:0] e, input int n);
        @(posedge clk); #1 ev = e;
        repeat (n) @(posedge clk);
        #1 ev = '0;
    endtask

    initial begin
        logic [63:0] q;
        int pulses, first;
        bit act;
        int hold, s;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        rd_chk("reset_control", 8'h00, 64'h0400);
        rd_chk("reset_overflow", 8'h02, 64'h0);
        rd_chk("reset_enable", 8'h01, 64'h0);
        rd_chk("reset_snap0", 8'h10, 64'h0);

        // ENABLE=1, 10 cycles of events on ch0/ch1, snapshot
        wr_reg(8'h01, 64'h1);
        run_ev(4'h3, 10);
        wr_reg(8'h00, 64'h1);
        rd_chk("snap0_ten", 8'h10, 64'd10);
        rd_chk("snap1_disabled", 8'h11, 64'd0);
        rd_chk("control_sv", 8'h00, 64'h0401);

        // clear write held 6 cycles
        @(posedge clk); #1;
        addr = 8'h00; wd = 64'h2; wr = 1'b1;
        pulses = 0; first = -1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (vld) begin pulses++; if (first < 0) first = i; end
        end
        wr = 1'b0;
        check("held_pulse_count", 64'(pulses), 64'd1);
        check("held_pulse_pos", 64'(first), 64'd0);
        rd_chk("clear_sv", 8'h00, 64'h0400);
        wr_reg(8'h00, 64'h1);
        rd_chk("cleared_counter", 8'h10, 64'd0);
        wr_reg(8'h00, 64'h3);
        rd_chk("snap_clr_sv", 8'h00, 64'h0400);

        // snapshot coincident with an increment
        wr_reg(8'h00, 64'h2);
        run_ev(4'h1, 5);
        xfer(1, 8'h00, 64'h1, 4'h1, q);
        rd_chk("snap_pre_inc", 8'h10, 64'd5);
        wr_reg(8'h00, 64'h1);
        rd_chk("snap_post_inc", 8'h10, 64'd6);

        // 257 events on an 8-bit counter
        wr_reg(8'h00, 64'h2);
        run_ev(4'h1, 257);
        wr_reg(8'h00, 64'h1);
        rd_chk("wrap_snap", 8'h10, 64'd1);
        rd_chk("wrap_ovf", 8'h02, 64'h1);
        wr_reg(8'h02, 64'h1);
        rd_chk("ovf_w1c", 8'h02, 64'h0);

`ifdef EVENT_COUNTER_SATURATE_EN
        wr_reg(8'h03, 64'h1);
        rd_chk("mode_rw", 8'h03, 64'h1);
        wr_reg(8'h00, 64'h2);
        run_ev(4'h1, 300);
        wr_reg(8'h00, 64'h1);
        rd_chk("sat_snap", 8'h10, 64'hFF);
        rd_chk("sat_ovf", 8'h02, 64'h1);
        wr_reg(8'h03, 64'h0);
        wr_reg(8'h02, 64'hF);
`else
        wr_reg(8'h03, 64'h1);
        rd_chk("mode_disabled", 8'h03, 64'h0);
`endif

        // simultaneous read+write: write wins
        xfer(2, 8'h01, 64'h5, '0, q);
        rd_chk("rw_both_write", 8'h01, 64'h5);

        rd_chk("unmapped", 8'h7F, 64'h0);

        // reset in the middle of a held request
        wr_reg(8'h01, 64'hF);
        run_ev(4'hF, 3);
        wr_reg(8'h00, 64'h1);
        @(posedge clk); #1;
        addr = 8'h01; rd = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_no_pulse", 64'(vld), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_serviced", 64'(vld), 64'd1);
        check("post_rst_enable", rdata, 64'd0);
        @(posedge clk); #1;
        check("post_rst_single", 64'(vld), 64'd0);
        rd = 1'b0;
        rd_chk("after_rst_ctrl", 8'h00, 64'h0400);
        rd_chk("after_rst_snap3", 8'h13, 64'h0);
        rd_chk("after_rst_ovf", 8'h02, 64'h0);

        // randomized traffic
        wr_reg(8'h01, 64'hF);
        act = 1'b0; hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            ev = NC'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            if (act) begin
                if (vld) begin
                    act = 1'b0; rd = 1'b0; wr = 1'b0;
                end else begin
                    hold++;
                    if (hold > 4) begin
                        check("rand_timeout", 64'd1, 64'd0);
                        act = 1'b0; rd = 1'b0; wr = 1'b0;
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                s = $urandom_range(0, 9);
                case (s)
                    0, 1:    addr = 8'h00;
                    2:       addr = 8'h01;
                    3:       addr = 8'h02;
                    4:       addr = 8'h03;
                    5, 6:    addr = 8'h10 + 8'($urandom_range(0, 3));
                    7:       addr = 8'h14;
                    8:       addr = 8'h7F;
                    default: addr = 8'($urandom);
                endcase
                wd = {$urandom, $urandom};
                if (addr == 8'h00) begin
                    s = $urandom_range(0, 9);
                    wd = (s == 0) ? 64'h2 : (s == 1) ? 64'h3 : 64'h1;
                end
                s = $urandom_range(0, 9);
                wr = (s < 4) || (s == 9);
                rd = (s >= 4);
                act = 1'b1; hold = 0;
            end
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; rst = 1'b0; ev = '0;
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
